spi_flash_rd_seq: RTL

Word-read sequencer in front of the SPI byte engine (`p23_spi`). It turns a 32-bit read request from the CPU/XIP side into a complete SPI-flash READ transaction: assert CS, send opcode and 24-bit address, receive 4 bytes, release CS. It drives only the engine's bus-side port (`ctrl`/`wdata`/`wstrb`/`valid`/`ready`/`rdata`) and never touches SPI pins.

---
 rtl/spi_flash_pkg.sv | 31 +++
 rtl/spi_flash_byte_xfer.sv | 74 +++++++
 rtl/spi_flash_rd_seq.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI-flash word-read sequencer.
// Fast read (opcode plus dummy byte) is selected in the top by SPI_FLASH_FAST_READ_EN.
package spi_flash_pkg;

  localparam logic [7:0] DEF_READ_OP = 8'h03;
  localparam logic [7:0] DEF_FAST_OP = 8'h0B;

  localparam logic CTRL_CS   = 1'b0;
  localparam logic CTRL_DATA = 1'b1;

  localparam int unsigned STATUS_BIT = 31;

  typedef enum logic [2:0] {
    StIdle,
    StCsOn,
    StCmd,
    StData,
    StCsOff,
    StDone
  } top_state_e;

  typedef enum logic [2:0] {
    BtIdle,
    BtWr,
    BtWrGap,
    BtPoll,
    BtPollGap,
    BtRd
  } byte_state_e;

endpackage

// File: rtl/spi_flash_byte_xfer.sv
// One byte exchange through the SPI engine: data write, status poll until idle, data read.
// Every access is followed by a cycle with spi_valid low so the engine never re-triggers.
module spi_flash_byte_xfer
  import spi_flash_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start_i,
  input  logic [7:0]  tx_i,
  output logic        done_o,
  output logic [7:0]  rx_o,
  output logic        spi_valid_o,
  output logic        spi_ctrl_o,
  output logic [3:0]  spi_wstrb_o,
  output logic [31:0] spi_wdata_o,
  input  logic        spi_ready_i,
  input  logic [31:0] spi_rdata_i
);

  byte_state_e state_q, state_d;
  logic [7:0]  tx_q, rx_q;
  logic        stat_busy_q, done_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= BtIdle;
      tx_q        <= 8'h00;
      rx_q        <= 8'h00;
      stat_busy_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == BtRd) && spi_ready_i;
      if ((state_q == BtIdle) && start_i) tx_q <= tx_i;
      if ((state_q == BtPoll) && spi_ready_i) stat_busy_q <= spi_rdata_i[STATUS_BIT];
      if ((state_q == BtRd) && spi_ready_i) rx_q <= spi_rdata_i[7:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    spi_valid_o = 1'b0;
    spi_ctrl_o  = CTRL_CS;
    spi_wstrb_o = 4'b0000;
    spi_wdata_o = 32'h0;
    unique case (state_q)
      BtIdle: if (start_i) state_d = BtWr;
      BtWr: begin
        spi_valid_o = 1'b1;
        spi_ctrl_o  = CTRL_DATA;
        spi_wstrb_o = 4'b0001;
        spi_wdata_o = {24'h0, tx_q};
        if (spi_ready_i) state_d = BtWrGap;
      end
      BtWrGap: state_d = BtPoll;
      BtPoll: begin
        spi_valid_o = 1'b1;
        if (spi_ready_i) state_d = BtPollGap;
      end
      // Re-poll after the gap while the engine still reports a transfer in progress.
      BtPollGap: state_d = stat_busy_q ? BtPoll : BtRd;
      BtRd: begin
        spi_valid_o = 1'b1;
        spi_ctrl_o  = CTRL_DATA;
        if (spi_ready_i) state_d = BtIdle;
      end
      default: state_d = BtIdle;
    endcase
  end

  assign done_o = done_q;
  assign rx_o   = rx_q;

endmodule

// File: rtl/spi_flash_rd_seq.sv
// SPI-flash word-read sequencer: CS on, opcode + 24-bit address, 4 data bytes, CS off.
// Define SPI_FLASH_FAST_READ_EN for fast read (FAST_OP plus one dummy byte).
module spi_flash_rd_seq
  import spi_flash_pkg::*;
#(
  parameter logic [7:0] READ_OP = DEF_READ_OP,
  parameter logic [7:0] FAST_OP = DEF_FAST_OP
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid_i,
  input  logic [23:0] req_addr_i,
  output logic        req_ready_o,
  output logic [31:0] req_rdata_o,
  output logic        busy_o,
  output logic        spi_ctrl_o,
  output logic        spi_valid_o,
  output logic [3:0]  spi_wstrb_o,
  output logic [31:0] spi_wdata_o,
  input  logic        spi_ready_i,
  input  logic [31:0] spi_rdata_i
);

`ifdef SPI_FLASH_FAST_READ_EN
  localparam bit         FastEn     = 1'b1;
  localparam logic [2:0] LastCmdIdx = 3'd4;
`else
  localparam bit         FastEn     = 1'b0;
  localparam logic [2:0] LastCmdIdx = 3'd3;
`endif
  localparam logic [7:0] Opcode = FastEn ? FAST_OP : READ_OP;

  top_state_e  state_q, state_d;
  logic [23:0] addr_q, addr_d;
  logic [2:0]  idx_q, idx_d;
  logic        start_q, start_d;
  logic        busy_q, busy_d;
  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;

  logic        cs_valid, cs_assert;
  logic [7:0]  tx_byte, bx_rx;
  logic        bx_done, bx_valid, bx_ctrl;
  logic [3:0]  bx_wstrb;
  logic [31:0] bx_wdata;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
      addr_q  <= 24'h0;
      idx_q   <= 3'd0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    idx_d     = idx_q;
    start_d   = 1'b0;
    busy_d    = busy_q;
    ready_d   = 1'b0;
    rdata_d   = rdata_q;
    cs_valid  = 1'b0;
    cs_assert = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          addr_d  = req_addr_i;
          busy_d  = 1'b1;
          state_d = StCsOn;
        end
      end
      StCsOn: begin
        cs_valid  = 1'b1;
        cs_assert = 1'b1;
        if (spi_ready_i) begin
          idx_d   = 3'd0;
          start_d = 1'b1;
          state_d = StCmd;
        end
      end
      StCmd: begin
        if (bx_done) begin
          start_d = 1'b1;
          if (idx_q == LastCmdIdx) begin
            idx_d   = 3'd0;
            state_d = StData;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      StData: begin
        if (bx_done) begin
          rdata_d[{idx_q[1:0], 3'b000} +: 8] = bx_rx;
          if (idx_q == 3'd3) begin
            state_d = StCsOff;
          end else begin
            idx_d   = idx_q + 3'd1;
            start_d = 1'b1;
          end
        end
      end
      StCsOff: begin
        cs_valid = 1'b1;
        if (spi_ready_i) begin
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = StDone;
        end
      end
      // A request seen here waits for the next IDLE cycle.
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    tx_byte = 8'h00;
    if (state_q == StCmd) begin
      unique case (idx_q)
        3'd0:    tx_byte = Opcode;
        3'd1:    tx_byte = addr_q[23:16];
        3'd2:    tx_byte = addr_q[15:8];
        3'd3:    tx_byte = addr_q[7:0];
        default: tx_byte = 8'h00;
      endcase
    end
  end

  spi_flash_byte_xfer u_byte_xfer (
    .clk         (clk),
    .resetn      (resetn),
    .start_i     (start_q),
    .tx_i        (tx_byte),
    .done_o      (bx_done),
    .rx_o        (bx_rx),
    .spi_valid_o (bx_valid),
    .spi_ctrl_o  (bx_ctrl),
    .spi_wstrb_o (bx_wstrb),
    .spi_wdata_o (bx_wdata),
    .spi_ready_i (spi_ready_i),
    .spi_rdata_i (spi_rdata_i)
  );

  // CS accesses are owned by the top; byte exchanges by the sub-module.
  assign spi_valid_o = cs_valid | bx_valid;
  assign spi_ctrl_o  = cs_valid ? CTRL_CS : bx_ctrl;
  assign spi_wstrb_o = cs_valid ? 4'b0001 : bx_wstrb;
  assign spi_wdata_o = cs_valid ? {31'h0, cs_assert} : bx_wdata;

  assign req_ready_o = ready_q;
  assign req_rdata_o = rdata_q;
  assign busy_o      = busy_q;

endmodule
